dispatch_ctrl: RTL and testbench
================================

// Module: dispatch_ctrl
// PURPOSE
//  Dispatch scheduler between the decoder and the out-of-order back end. Gates the decoder/IQ pop,
//  allocates ROB tags in order and routes each instruction to RS or LSB by occupancy credits.
//  Owns the ROB/RS/LSB full flags the decoder stalls on; recovers from a flush in one cycle.
// PARAMETERS
//  ROB_SIZE   16  ROB entries; power of two (tail wraps by truncation)
//  ROB_TAG_W  4   log2(ROB_SIZE)
//  RS_SIZE    8   RS entries (ALU, branch, jump, lui, auipc)
//  LSB_SIZE   8   LSB entries (loads, stores)
// PORTS
//  clk_in        in   1          clock
//  rst_in        in   1          reset, synchronous, active-high
//  rdy_in        in   1          global enable; low = freeze
//  clear         in   1          mispredict flush
//  dec_valid     in   1          decoded instruction present
//  dec_is_mem    in   1          1 = load/store (LSB), 0 = RS
//  dec_ready     out  1          accept/pop; comb. from registered state + dec_is_mem
//  rob_commit    in   1          ROB head retired; frees one ROB credit
//  rs_release    in   1          RS entry issued; frees one RS credit
//  lsb_release   in   1          LSB entry retired; frees one LSB credit
//  disp_valid    out  1          one-cycle dispatch pulse
//  disp_rob_tag  out  ROB_TAG_W  tag allocated to the dispatched instruction
//  disp_to_rs    out  1          dispatched instruction targets RS
//  disp_to_lsb   out  1          dispatched instruction targets LSB
//  rob_full      out  1          rob_cnt == ROB_SIZE
//  rs_full       out  1          rs_cnt == RS_SIZE
//  lsb_full      out  1          lsb_cnt == LSB_SIZE
// BEHAVIOUR
//  - State: rob_cnt/rs_cnt/lsb_cnt (each wide enough to hold its SIZE), rob_tail, FSM {RUN, STALL, FLUSH}.
//  - Reset: counts 0, rob_tail 0, FSM RUN; disp_* outputs 0; full flags 0; dec_ready 0 in reset cycle.
//  - dec_ready = rdy_in & !rst_in & !clear & FSM!=FLUSH & !rob_full & (dec_is_mem ? !lsb_full : !rs_full).
//  - Accept = dec_valid & dec_ready. Next edge: disp_valid=1, disp_rob_tag=rob_tail at accept,
//    disp_to_lsb=dec_is_mem, disp_to_rs=!dec_is_mem; rob_tail+1 mod ROB_SIZE; rob_cnt+1; target cnt+1.
//  - Latency: accept to disp_valid is 1 cycle; disp_valid drops next cycle unless another accept. Max 1/cycle.
//  - In-order: a stalled head blocks everything behind it; no bypass across a full queue.
//  - Credits: each count is +1 on accept to that resource, -1 on its release. Same cycle: net 0.
//    A release at count 0 is ignored (saturate at 0). At full, accept impossible; the release alone decrements.
//  - FSM: RUN->STALL when dec_valid & !dec_ready & rdy_in & !clear. STALL->RUN on accept or !dec_valid.
//    any->FLUSH on clear. FLUSH->RUN after exactly one cycle.
//  - clear: next edge counts 0, rob_tail 0, disp_valid 0. Accept and releases in the clear cycle are dropped.
//    dec_ready held 0 in the clear cycle and the FLUSH cycle.
//  - rdy_in low: all registers hold (releases ignored), dec_ready 0, disp_valid forced 0. Resume is seamless.
//  - rst_in has priority over clear; clear has priority over accept/release.
// CONFIGURATION
//  - DISPATCH_STAT_EN defined: add outputs stat_disp_cnt[31:0] and stat_stall_cnt[31:0].
//    stat_disp_cnt +1 per accept; stat_stall_cnt +1 per cycle in STALL with rdy_in high.
//    Both wrap at 2^32, clear on rst_in only (not on clear), freeze when rdy_in low.
//  - DISPATCH_STAT_EN undefined: these ports and counters do not exist; all other behaviour identical.
// TESTING
//  1. Reset, 16 ALU inst, no releases -> tags 0..15; rob_full=1 after the 16th; 17th dec_ready=0; FSM STALL.
//     Use RS_SIZE=16 for this test so RS credits do not stall first.
//  2. Mem inst, 8 in a row -> lsb_full=1; 9th mem stalls; the ALU inst queued behind it is not dispatched.
//     One lsb_release -> the 9th is accepted next cycle, disp_to_lsb=1.
//  3. rs_cnt=7, ALU accept + rs_release same cycle -> rs_cnt stays 7; rs_release at rs_cnt=0 -> stays 0.
//  4. rob_cnt=5, tail=5, clear pulse -> next cycle counts 0, tail 0, FSM FLUSH, dec_ready 0.
//     Following cycle RUN; next dispatch tag=0.
//  5. rdy_in low 3 cycles mid-stream with dec_valid=1 and releases asserted -> no dispatch, counts unchanged.
//     Resume: next tag continues in sequence.
//  6. 20 dispatches with a rob_commit every cycle after the 4th -> tag sequence ...14,15,0,1,2,3.
//     With DISPATCH_STAT_EN: stat_disp_cnt=20.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: in-order dispatch scheduler; allocates ROB tags and routes to RS/LSB by credits.
// Optional statistics counters are enabled by defining DISPATCH_STAT_EN.
module dispatch_ctrl #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_TAG_W = 4,
  parameter int RS_SIZE   = 8,
  parameter int LSB_SIZE  = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 dec_valid,
  input  logic                 dec_is_mem,
  output logic                 dec_ready,
  input  logic                 rob_commit,
  input  logic                 rs_release,
  input  logic                 lsb_release,
  output logic                 disp_valid,
  output logic [ROB_TAG_W-1:0] disp_rob_tag,
  output logic                 disp_to_rs,
  output logic                 disp_to_lsb,
  output logic                 rob_full,
  output logic                 rs_full,
  output logic                 lsb_full
`ifdef DISPATCH_STAT_EN
  ,
  output logic [31:0]          stat_disp_cnt,
  output logic [31:0]          stat_stall_cnt
`endif
);

  localparam int ROB_CW = $clog2(ROB_SIZE + 1);
  localparam int RS_CW  = $clog2(RS_SIZE + 1);
  localparam int LSB_CW = $clog2(LSB_SIZE + 1);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t                state, state_nxt;
  logic [ROB_CW-1:0]     rob_cnt;
  logic [RS_CW-1:0]      rs_cnt;
  logic [LSB_CW-1:0]     lsb_cnt;
  logic [ROB_TAG_W-1:0]  rob_tail;
  logic                  accept;

  // Credit update: +1 on allocation, -1 on release, a release against an empty pool is dropped.
  function automatic logic [31:0] sat_credit(input logic [31:0] cnt, input logic inc,
                                             input logic rel);
    return cnt + 32'(inc) - 32'(rel && (cnt != 32'd0));
  endfunction

  assign rob_full  = (rob_cnt == ROB_CW'(ROB_SIZE));
  assign rs_full   = (rs_cnt  == RS_CW'(RS_SIZE));
  assign lsb_full  = (lsb_cnt == LSB_CW'(LSB_SIZE));

  assign dec_ready = rdy_in & ~rst_in & ~clear & (state != FLUSH) & ~rob_full &
                     (dec_is_mem ? ~lsb_full : ~rs_full);
  assign accept    = dec_valid & dec_ready;

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        RUN:     if (dec_valid && !dec_ready) state_nxt = STALL;
        STALL:   if (accept || !dec_valid)    state_nxt = RUN;
        FLUSH:   state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= RUN;
      rob_cnt      <= '0;
      rs_cnt       <= '0;
      lsb_cnt      <= '0;
      rob_tail     <= '0;
      disp_valid   <= 1'b0;
      disp_to_rs   <= 1'b0;
      disp_to_lsb  <= 1'b0;
      disp_rob_tag <= '0;
    end else if (!rdy_in) begin
      disp_valid   <= 1'b0;
      disp_to_rs   <= 1'b0;
      disp_to_lsb  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        rob_cnt     <= '0;
        rs_cnt      <= '0;
        lsb_cnt     <= '0;
        rob_tail    <= '0;
        disp_valid  <= 1'b0;
        disp_to_rs  <= 1'b0;
        disp_to_lsb <= 1'b0;
      end else begin
        rob_cnt     <= ROB_CW'(sat_credit(32'(rob_cnt), accept, rob_commit));
        rs_cnt      <= RS_CW'(sat_credit(32'(rs_cnt), accept & ~dec_is_mem, rs_release));
        lsb_cnt     <= LSB_CW'(sat_credit(32'(lsb_cnt), accept & dec_is_mem, lsb_release));
        disp_valid  <= accept;
        disp_to_rs  <= accept & ~dec_is_mem;
        disp_to_lsb <= accept & dec_is_mem;
        if (accept) begin
          disp_rob_tag <= rob_tail;
          rob_tail     <= rob_tail + ROB_TAG_W'(1);
        end
      end
    end
  end

`ifdef DISPATCH_STAT_EN
  // Statistics survive a flush; only reset clears them.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_disp_cnt  <= '0;
      stat_stall_cnt <= '0;
    end else if (rdy_in) begin
      if (accept)         stat_disp_cnt  <= stat_disp_cnt + 32'd1;
      if (state == STALL) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios plus randomized traffic against
// a queue-based occupancy model.
module tb_dispatch_ctrl;
  localparam int ROB = 16, TW = 4, RS = 16, LSB = 8;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear, dec_valid, dec_is_mem, rob_commit, rs_release, lsb_release;
  logic dec_ready, disp_valid, disp_to_rs, disp_to_lsb, rob_full, rs_full, lsb_full;
  logic [TW-1:0] disp_rob_tag;
`ifdef DISPATCH_STAT_EN
  logic [31:0] stat_disp_cnt, stat_stall_cnt;
`endif

  int total = 0, bad = 0;

  // Reference model: outstanding ROB tags in a queue, plain occupancy counts for RS/LSB.
  int          rob_q[$];
  int          m_rs = 0, m_lsb = 0, m_tail = 0;
  bit          m_flush = 0, m_stall_st = 0;
  int unsigned m_disp_cnt = 0, m_stall_cnt = 0;
  bit          e_ready = 0, e_valid = 0, e_mem = 0;
  logic [TW-1:0] e_tag = '0;
  logic        s_ready;

  dispatch_ctrl #(.ROB_SIZE(ROB), .ROB_TAG_W(TW), .RS_SIZE(RS), .LSB_SIZE(LSB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .dec_valid(dec_valid), .dec_is_mem(dec_is_mem), .dec_ready(dec_ready),
    .rob_commit(rob_commit), .rs_release(rs_release), .lsb_release(lsb_release),
    .disp_valid(disp_valid), .disp_rob_tag(disp_rob_tag),
    .disp_to_rs(disp_to_rs), .disp_to_lsb(disp_to_lsb),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full)
`ifdef DISPATCH_STAT_EN
    , .stat_disp_cnt(stat_disp_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit model_ready();
    return rdy_in && !rst_in && !clear && !m_flush && (rob_q.size() < ROB) &&
           (dec_is_mem ? (m_lsb < LSB) : (m_rs < RS));
  endfunction

  function automatic logic [10:0] act_vec();
    return {s_ready, disp_valid, disp_to_rs, disp_to_lsb, disp_rob_tag, rob_full, rs_full, lsb_full};
  endfunction

  function automatic logic [10:0] exp_vec();
    logic rf, sf, lf;
    rf = (rob_q.size() == ROB);
    sf = (m_rs == RS);
    lf = (m_lsb == LSB);
    return {e_ready, e_valid, e_valid & ~e_mem, e_valid & e_mem, e_tag, rf, sf, lf};
  endfunction

  task automatic drive(input bit v, input bit m, input bit rc, input bit rsr, input bit lr);
    dec_valid = v; dec_is_mem = m; rob_commit = rc; rs_release = rsr; lsb_release = lr;
  endtask

  // One clock: sample dec_ready before the edge, advance the model at the edge.
  task automatic tick();
    bit acc;
    #1;
    e_ready = model_ready();
    s_ready = dec_ready;
    acc = dec_valid && e_ready;
    @(posedge clk_in);
    if (rst_in) begin
      rob_q.delete(); m_rs = 0; m_lsb = 0; m_tail = 0; m_flush = 0; m_stall_st = 0;
      m_disp_cnt = 0; m_stall_cnt = 0; e_valid = 0; e_mem = 0; e_tag = '0;
    end else if (!rdy_in) begin
      e_valid = 0; e_mem = 0;
    end else begin
      if (m_stall_st) m_stall_cnt++;
      if (acc) m_disp_cnt++;
      if (clear) begin m_flush = 1; m_stall_st = 0; end
      else if (m_flush) m_flush = 0;
      else if (m_stall_st) begin if (acc || !dec_valid) m_stall_st = 0; end
      else if (dec_valid && !e_ready) m_stall_st = 1;
      if (clear) begin
        rob_q.delete(); m_rs = 0; m_lsb = 0; m_tail = 0; e_valid = 0; e_mem = 0;
      end else begin
        if (rob_commit && rob_q.size() > 0) void'(rob_q.pop_front());
        if (rs_release && m_rs > 0) m_rs--;
        if (lsb_release && m_lsb > 0) m_lsb--;
        e_valid = acc;
        e_mem = acc && dec_is_mem;
        if (acc) begin
          e_tag = TW'(m_tail);
          rob_q.push_back(m_tail);
          m_tail = (m_tail + 1) % ROB;
          if (dec_is_mem) m_lsb++; else m_rs++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1; rdy_in = 1; clear = 0;
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    rst_in = 0;
  endtask

  task automatic test_reset();
    rst_in = 1; rdy_in = 1; clear = 0;
    drive(1, 0, 0, 0, 0);
    tick();
    total++;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", s_ready); end
    tick();
    total++;
    if (act_vec() !== exp_vec() || disp_valid !== 1'b0 || rob_full !== 1'b0) begin
      bad++; $display("FAIL reset_state got=%h want=%h", act_vec(), exp_vec());
    end
    rst_in = 0;
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_rob_fill();
    do_reset();
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      tick();
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++; $display("FAIL rob_fill cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      if (i < 16) begin
        total++;
        if (disp_valid !== 1'b1 || disp_rob_tag !== TW'(i)) begin
          bad++; $display("FAIL rob_fill_tag cyc=%0d got=%b/%0d want=1/%0d", i, disp_valid, disp_rob_tag, i);
        end
      end
    end
    total++;
    if (rob_full !== 1'b1 || s_ready !== 1'b0 || disp_valid !== 1'b0) begin
      bad++; $display("FAIL rob_full_stall got=%b%b%b want=100", rob_full, s_ready, disp_valid);
    end
    tick();
`ifdef DISPATCH_STAT_EN
    total++;
    if (stat_stall_cnt !== 32'(m_stall_cnt) || m_stall_cnt != 1) begin
      bad++; $display("FAIL stall_stat got=%0d want=1", stat_stall_cnt);
    end
`endif
  endtask

  task automatic test_lsb_stall();
    do_reset();
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++; $display("FAIL lsb_fill cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
    end
    total++;
    if (lsb_full !== 1'b1 || disp_valid !== 1'b0 || s_ready !== 1'b0) begin
      bad++; $display("FAIL lsb_stall got=%b%b%b want=100", lsb_full, disp_valid, s_ready);
    end
    drive(1, 1, 0, 0, 1);
    tick();
    drive(1, 1, 0, 0, 0);
    tick();
    total++;
    if (disp_valid !== 1'b1 || disp_to_lsb !== 1'b1 || disp_rob_tag !== TW'(8)) begin
      bad++; $display("FAIL lsb_resume got=%b%b/%0d want=11/8", disp_valid, disp_to_lsb, disp_rob_tag);
    end
    drive(1, 0, 0, 0, 0);
    tick();
    total++;
    if (act_vec() !== exp_vec() || disp_to_rs !== 1'b1 || disp_rob_tag !== TW'(9)) begin
      bad++; $display("FAIL alu_after_mem got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_credits();
    int n;
    do_reset();
    drive(1, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) tick();
    drive(1, 0, 1, 1, 0);
    tick();
    drive(1, 0, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++; $display("FAIL credit_fill cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      if (disp_valid === 1'b1) n++;
    end
    total++;
    if (n != RS - 7 || rs_full !== 1'b1) begin
      bad++; $display("FAIL same_cycle_net got=%0d want=%0d", n, RS - 7);
    end
    do_reset();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick();
    drive(1, 0, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (disp_valid === 1'b1) n++;
    end
    total++;
    if (n != RS || rs_full !== 1'b1) begin
      bad++; $display("FAIL release_at_zero got=%0d want=%0d", n, RS);
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, i[0], 0, 0, 0);
      tick();
    end
    clear = 1;
    drive(1, 0, 1, 1, 1);
    tick();
    total++;
    if (s_ready !== 1'b0 || act_vec() !== exp_vec()) begin
      bad++; $display("FAIL clear_cycle got=%h want=%h", act_vec(), exp_vec());
    end
    clear = 0;
    drive(1, 0, 0, 0, 0);
    tick();
    total++;
    if (s_ready !== 1'b0 || disp_valid !== 1'b0 || act_vec() !== exp_vec()) begin
      bad++; $display("FAIL flush_cycle got=%h want=%h", act_vec(), exp_vec());
    end
    tick();
    total++;
    if (s_ready !== 1'b1 || disp_valid !== 1'b1 || disp_rob_tag !== TW'(0)) begin
      bad++; $display("FAIL post_flush got=%b%b/%0d want=11/0", s_ready, disp_valid, disp_rob_tag);
    end
  endtask

  task automatic test_rdy_low();
    do_reset();
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    rdy_in = 0;
    drive(1, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (s_ready !== 1'b0 || disp_valid !== 1'b0 || act_vec() !== exp_vec()) begin
        bad++; $display("FAIL rdy_low cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
    end
    rdy_in = 1;
    drive(1, 0, 0, 0, 0);
    tick();
    total++;
    if (disp_valid !== 1'b1 || disp_rob_tag !== TW'(3) || act_vec() !== exp_vec()) begin
      bad++; $display("FAIL rdy_resume got=%b/%0d want=1/3", disp_valid, disp_rob_tag);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, i >= 4, 1, 0);
      tick();
      total++;
      if (disp_valid !== 1'b1 || disp_rob_tag !== TW'(i % 16) || act_vec() !== exp_vec()) begin
        bad++; $display("FAIL wrap cyc=%0d got=%b/%0d want=1/%0d", i, disp_valid, disp_rob_tag, i % 16);
      end
    end
`ifdef DISPATCH_STAT_EN
    total++;
    if (stat_disp_cnt !== 32'd20) begin
      bad++; $display("FAIL disp_stat got=%0d want=20", stat_disp_cnt);
    end
`endif
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst_in = ($urandom_range(149) == 0);
      rdy_in = ($urandom_range(7) != 0);
      clear  = rdy_in && ($urandom_range(29) == 0);
      drive($urandom_range(3) != 0, $urandom_range(1), $urandom_range(2) == 0,
            $urandom_range(2) == 0, $urandom_range(2) == 0);
      tick();
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
    end
`ifdef DISPATCH_STAT_EN
    total++;
    if (stat_disp_cnt !== 32'(m_disp_cnt) || stat_stall_cnt !== 32'(m_stall_cnt)) begin
      bad++; $display("FAIL random_stats got=%0d/%0d want=%0d/%0d",
                      stat_disp_cnt, stat_stall_cnt, m_disp_cnt, m_stall_cnt);
    end
`endif
    rst_in = 0; rdy_in = 1; clear = 0;
  endtask

  initial begin
    test_reset();
    test_rob_fill();
    test_lsb_stall();
    test_credits();
    test_clear();
    test_rdy_low();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
